// File: rtl/multi_latch_pkg.sv
// Shared datapath constants for the word storage register.
// Latency and backpressure: not applicable, declarations only.
package multi_latch_pkg;
   localparam int WORD_W = 12;

   typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/multi_latch_tristate_buf.sv
// Word-wide tri-state driver onto a shared bus.
// Latency: combinational. Backpressure: none; the bus floats while disabled.
module tristate_buf
   import multi_latch_pkg::*;
#(
   parameter int WIDTH = WORD_W
) (
   input  logic [WIDTH-1:0] data,
   input  logic             en,
   output wire  [WIDTH-1:0] bus
);

   assign bus = en ? data : {WIDTH{1'bz}};

endmodule

// File: rtl/multi_latch.sv
// Word register with async clear and two independent tri-state read ports.
// Latency: capture on latch rise, reads combinational. Backpressure: none.
module multi_latch
   import multi_latch_pkg::*;
#(
   parameter int WIDTH = WORD_W
) (
   input  logic             latch,
   input  logic             clear,
   input  logic [WIDTH-1:0] in,
   input  logic             oe1,
   input  logic             oe2,
   output wire  [WIDTH-1:0] out1,
   output wire  [WIDTH-1:0] out2
);

   logic [WIDTH-1:0] q;

   // Clear is level-sensitive, so a latch edge arriving while it is held is dropped.
   always_ff @(posedge latch or posedge clear) begin
      if (clear) begin
         q <= '0;
      end else begin
         q <= in;
      end
   end

   tristate_buf #(.WIDTH(WIDTH)) u_port1 (
      .data (q),
      .en   (oe1),
      .bus  (out1)
   );

   tristate_buf #(.WIDTH(WIDTH)) u_port2 (
      .data (q),
      .en   (oe2),
      .bus  (out2)
   );

endmodule

// File: tb/tb_multi_latch.sv
// Directed bench for multi_latch: vector table plus hand sequences for clear corner cases.
// A floating port is detected by letting the bench drive a probe pattern onto that bus.
module tb_multi_latch;
   localparam int          W     = 12;
   localparam logic [11:0] PROBE = 12'hA5A;
   localparam int          ACT_NONE  = 0;
   localparam int          ACT_CLEAR = 1;
   localparam int          ACT_LATCH = 2;

   logic          latch;
   logic          clear;
   logic [W-1:0]  in;
   logic          oe1;
   logic          oe2;
   wire  [W-1:0]  out1;
   wire  [W-1:0]  out2;
   logic          probe1;
   logic          probe2;

   int tests;
   int fails;

   assign out1 = probe1 ? PROBE : {W{1'bz}};
   assign out2 = probe2 ? PROBE : {W{1'bz}};

   multi_latch #(.WIDTH(W)) dut (
      .latch (latch),
      .clear (clear),
      .in    (in),
      .oe1   (oe1),
      .oe2   (oe2),
      .out1  (out1),
      .out2  (out2)
   );

   typedef struct {
      int           act;
      logic [W-1:0] din;
      logic         en1;
      logic         en2;
      logic [W-1:0] exp1;
      bit           z1;
      logic [W-1:0] exp2;
      bit           z2;
   } vec_t;

   vec_t vecs [10];

   task automatic pulse_latch();
      #5 latch = 1'b1;
      #5 latch = 1'b0;
      #5;
   endtask

   task automatic pulse_clear();
      #5 clear = 1'b1;
      #5 clear = 1'b0;
      #5;
   endtask

   task automatic check_port(input int id, input int port, input logic [W-1:0] exp, input bit expz);
      logic [W-1:0] act;
      tests++;
      if (expz) begin
         if (port == 1) probe1 = 1'b1;
         else           probe2 = 1'b1;
         #1;
         act = (port == 1) ? out1 : out2;
         probe1 = 1'b0;
         probe2 = 1'b0;
         #1;
         if (act !== PROBE) begin
            fails++;
            $display("FAIL case%0d out%0d: bus read %h with probe %h driven, required Z (undriven)",
                     id, port, act, PROBE);
         end
      end else begin
         #1;
         act = (port == 1) ? out1 : out2;
         if (act !== exp) begin
            fails++;
            $display("FAIL case%0d out%0d: got %h, required %h", id, port, act, exp);
         end
      end
   endtask

   task automatic check_both(input int id, input logic [W-1:0] e1, input bit z1,
                             input logic [W-1:0] e2, input bit z2);
      check_port(id, 1, e1, z1);
      check_port(id, 2, e2, z2);
   endtask

   initial begin
      tests  = 0;
      fails  = 0;
      latch  = 1'b0;
      clear  = 1'b1;
      in     = '0;
      oe1    = 1'b0;
      oe2    = 1'b0;
      probe1 = 1'b0;
      probe2 = 1'b0;
      #10 clear = 1'b0;
      #5;

      //            act        in       oe1   oe2   exp1     z1  exp2     z2
      vecs[0] = '{ACT_CLEAR, 12'h123, 1'b1, 1'b1, 12'h000, 0, 12'h000, 0};
      vecs[1] = '{ACT_NONE,  12'h123, 1'b0, 1'b0, 12'h000, 1, 12'h000, 1};
      vecs[2] = '{ACT_LATCH, 12'h123, 1'b0, 1'b0, 12'h000, 1, 12'h000, 1};
      vecs[3] = '{ACT_NONE,  12'h123, 1'b1, 1'b0, 12'h123, 0, 12'h000, 1};
      vecs[4] = '{ACT_NONE,  12'h123, 1'b1, 1'b1, 12'h123, 0, 12'h123, 0};
      vecs[5] = '{ACT_NONE,  12'h123, 1'b0, 1'b1, 12'h000, 1, 12'h123, 0};
      vecs[6] = '{ACT_NONE,  12'hFFF, 1'b1, 1'b1, 12'h123, 0, 12'h123, 0};
      vecs[7] = '{ACT_LATCH, 12'hFFF, 1'b1, 1'b1, 12'hFFF, 0, 12'hFFF, 0};
      vecs[8] = '{ACT_LATCH, 12'h5A5, 1'b1, 1'b0, 12'h5A5, 0, 12'h000, 1};
      vecs[9] = '{ACT_NONE,  12'h5A5, 1'b0, 1'b0, 12'h000, 1, 12'h000, 1};

      for (int i = 0; i < 10; i++) begin
         in  = vecs[i].din;
         oe1 = vecs[i].en1;
         oe2 = vecs[i].en2;
         if (vecs[i].act == ACT_CLEAR) pulse_clear();
         else if (vecs[i].act == ACT_LATCH) pulse_latch();
         else #5;
         check_both(i, vecs[i].exp1, vecs[i].z1, vecs[i].exp2, vecs[i].z2);
      end

      // Async clear while both ports drive: no latch edge involved.
      in  = 12'h123;
      oe1 = 1'b1;
      oe2 = 1'b1;
      pulse_latch();
      check_both(100, 12'h123, 0, 12'h123, 0);
      clear = 1'b1;
      check_both(101, 12'h000, 0, 12'h000, 0);

      // Latch edge while clear is held is ignored; releasing clear does not capture.
      in = 12'h3C3;
      pulse_latch();
      check_both(102, 12'h000, 0, 12'h000, 0);
      clear = 1'b0;
      #5;
      check_both(103, 12'h000, 0, 12'h000, 0);
      pulse_latch();
      check_both(104, 12'h3C3, 0, 12'h3C3, 0);

      // Changing in while latch is high, then a falling edge, must not capture.
      #5 latch = 1'b1;
      #5 in = 12'h0F0;
      #5 latch = 1'b0;
      #5;
      check_both(105, 12'h3C3, 0, 12'h3C3, 0);

      // Release ports one at a time; the other keeps driving.
      oe1 = 1'b0;
      #2;
      check_both(106, 12'h000, 1, 12'h3C3, 0);
      oe2 = 1'b0;
      #2;
      check_both(107, 12'h000, 1, 12'h000, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
